frv_asi_iter: RTL

FRV_ASI_ITER -- requirements
Module: frv_asi_iter

---
 rtl/frv_asi_iter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/frv_asi_iter.sv
// Iterative AES SubBytes and SHA2 sigma unit. The SHA2 class is built only
// when FRV_ASI_ITER_SHA2_EN is defined; otherwise those uops are illegal.
module frv_asi_iter #(
  parameter int XLEN       = 32,
  parameter int SBOX_LANES = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            asi_valid,
  input  logic            asi_flush,
  input  logic [3:0]      asi_uop,
  input  logic [XLEN-1:0] asi_rs1,
  output logic            asi_ready,
  output logic            asi_busy,
  output logic [XLEN-1:0] asi_result
);

  // Handshake: the requester holds asi_valid high with stable asi_uop/asi_rs1
  // until asi_ready; asi_ready marks the single cycle asi_result is valid.
  // Dropping asi_valid or raising asi_flush abandons the operation silently.

  localparam int NBYTES = XLEN / 8;
  localparam int C      = NBYTES / SBOX_LANES;
  localparam int CW     = (C > 1) ? $clog2(C) : 1;
  localparam int LW     = SBOX_LANES * 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] part_q, part_d;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  // Forward and inverse S-box share one field inverter per lane.
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] pre;
    logic [7:0] g;
    pre = inv ? (rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05) : x;
    g   = gf_inv(pre);
    return inv ? g : (g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63);
  endfunction

`ifdef FRV_ASI_ITER_SHA2_EN
  function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] x, input int n);
    return (x >> n) | (x << (XLEN - n));
  endfunction

  function automatic logic [XLEN-1:0] sha2_sigma(input logic [XLEN-1:0] x,
                                                 input logic [1:0] sel);
    logic [XLEN-1:0] r;
    r = '0;
    if (XLEN == 32) begin
      case (sel)
        2'd0:    r = ror(x, 7)  ^ ror(x, 18) ^ (x >> 3);
        2'd1:    r = ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
        2'd2:    r = ror(x, 2)  ^ ror(x, 13) ^ ror(x, 22);
        default: r = ror(x, 6)  ^ ror(x, 11) ^ ror(x, 25);
      endcase
    end else begin
      case (sel)
        2'd0:    r = ror(x, 1)  ^ ror(x, 8)  ^ (x >> 7);
        2'd1:    r = ror(x, 19) ^ ror(x, 61) ^ (x >> 6);
        2'd2:    r = ror(x, 28) ^ ror(x, 34) ^ ror(x, 39);
        default: r = ror(x, 14) ^ ror(x, 18) ^ ror(x, 41);
      endcase
    end
    return r;
  endfunction
`endif

  logic            is_aes;
  logic            is_sha;
  logic            last;
  logic [XLEN-1:0] aes_op;
  logic [XLEN-1:0] lane_src;
  logic [LW-1:0]   lane_out;
  logic [XLEN-1:0] new_word;
  logic [XLEN-1:0] aes_word;
  logic [XLEN-1:0] sha_word;
  int              shamt;

  always_comb begin
    is_aes   = (asi_uop[3:2] == 2'b00);
    aes_op   = asi_uop[1] ? {asi_rs1[7:0], asi_rs1[XLEN-1:8]} : asi_rs1;
    shamt    = int'(cnt_q) * LW;
    lane_src = aes_op >> shamt;
    lane_out = '0;
    for (int l = 0; l < SBOX_LANES; l++) begin
      lane_out[l*8 +: 8] = sbox(lane_src[l*8 +: 8], asi_uop[0]);
    end
    new_word = XLEN'(lane_out) << shamt;
    aes_word = part_q | new_word;
    last     = (cnt_q == CW'(C - 1));
`ifdef FRV_ASI_ITER_SHA2_EN
    is_sha   = (asi_uop[3:2] == 2'b01);
    sha_word = sha2_sigma(asi_rs1, asi_uop[1:0]);
`else
    is_sha   = 1'b0;
    sha_word = '0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    part_d     = part_q;
    asi_ready  = 1'b0;
    asi_result = '0;
    if (!g_resetn || !asi_valid || asi_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      part_d  = '0;
    end else if (is_aes) begin
      if (last) begin
        asi_ready  = 1'b1;
        asi_result = aes_word;
        state_d    = IDLE;
        cnt_d      = '0;
        part_d     = '0;
      end else begin
        state_d = BUSY;
        cnt_d   = cnt_q + CW'(1);
        part_d  = aes_word;
      end
    end else begin
      // SHA2 and illegal uops finish in the request cycle.
      asi_ready  = 1'b1;
      asi_result = is_sha ? sha_word : '0;
      state_d    = IDLE;
      cnt_d      = '0;
      part_d     = '0;
    end
  end

  assign asi_busy = (state_q == BUSY);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
    end
  end

endmodule
